// File: rtl/seg_scan_display_if.sv
// ----------------------------------------------------------------------------
// seg_scan_display_if
// Bundles the display data load port and the SEG/AN/frame pin outputs of
// seg_scan_display. The master side is board-top logic (or a bench), the
// slave side is the display driver.
// ----------------------------------------------------------------------------
interface seg_scan_display_if #(
   parameter int unsigned N_DIGITS = 8
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   din;
   logic [N_DIGITS-1:0]     den;
   logic [N_DIGITS-1:0]     dpin;
   logic [7:0]              SEG;
   logic [7:0]              AN;
   logic                    frame;

   modport master (
      output load, din, den, dpin,
      input  SEG, AN, frame
   );

   modport slave (
      input  load, din, den, dpin,
      output SEG, AN, frame
   );
endinterface : seg_scan_display_if

// File: rtl/seg_scan_display.sv
// ----------------------------------------------------------------------------
// seg_scan_display
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Data is written into a shadow bank on load and committed to the active bank
// only at a frame wrap, so a frame never shows a mix of old and new data.
// SEG/AN/frame are registered; SEG and AN change in the same cycle.
//
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//   defined     - zero digits above the most significant enabled non-zero
//                 digit are blanked (digit 0 always shown)
//   not defined - zero digits show '0'; only den blanks a digit
// ----------------------------------------------------------------------------
module seg_scan_display #(
   parameter int unsigned N_DIGITS = 8,
   parameter int unsigned CLK_DIV  = 100000
) (
   input  logic               clk,
   input  logic               rst,
   seg_scan_display_if.slave  bus
);

   localparam int unsigned DW = 4 * N_DIGITS;
   localparam int unsigned PW = $clog2(CLK_DIV + 1);
   localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   // Enables are held inverted (disable masks) so that the cleared state
   // lights every digit showing '0'.
   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic                  r_pending;
   logic [DW-1:0]         r_sh_din;
   logic [N_DIGITS-1:0]   r_sh_dis;
   logic [N_DIGITS-1:0]   r_sh_dp;
   logic [DW-1:0]         r_act_din;
   logic [N_DIGITS-1:0]   r_act_dis;
   logic [N_DIGITS-1:0]   r_act_dp;
   logic [7:0]            r_seg;
   logic [7:0]            r_an;
   logic                  r_frame;

   logic [PW-1:0]         w_presc_nxt;
   logic [IW-1:0]         w_idx_nxt;
   logic                  w_pending_nxt;
   logic [DW-1:0]         w_sh_din_nxt;
   logic [N_DIGITS-1:0]   w_sh_dis_nxt;
   logic [N_DIGITS-1:0]   w_sh_dp_nxt;
   logic [DW-1:0]         w_act_din_nxt;
   logic [N_DIGITS-1:0]   w_act_dis_nxt;
   logic [N_DIGITS-1:0]   w_act_dp_nxt;
   logic [7:0]            w_seg_nxt;
   logic [7:0]            w_an_nxt;
   logic                  w_frame_nxt;

   logic                  w_tick;
   logic                  w_wrap;
   logic [N_DIGITS-1:0]   w_blank;
   logic [3:0]            w_nib;
   logic                  w_en;
   logic                  w_dp;

   // Hex nibble to {g,f,e,d,c,b,a}, active low.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign w_tick = (r_presc == PRESC_LAST);
   assign w_wrap = w_tick && (r_idx == IDX_LAST);

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // Blank zero digits while every enabled digit above them is also zero.
   always_comb begin : blank_calc
      logic zero_above;
      w_blank    = '0;
      zero_above = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
         w_blank[i] = zero_above && (r_act_din[4*i +: 4] == 4'h0);
         if (!r_act_dis[i] && (r_act_din[4*i +: 4] != 4'h0))
            zero_above = 1'b0;
      end
   end
`else
   assign w_blank = '0;
`endif

   // Select the active data of the digit currently being scanned.
   always_comb begin
      w_nib = 4'h0;
      w_en  = 1'b0;
      w_dp  = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (r_idx == IW'(i)) begin
            w_nib = r_act_din[4*i +: 4];
            w_en  = !r_act_dis[i] && !w_blank[i];
            w_dp  = r_act_dp[i];
         end
      end
   end

   // Next-state: prescaler, scan index, shadow/active banks and pin outputs.
   always_comb begin
      w_presc_nxt   = r_presc;
      w_idx_nxt     = r_idx;
      w_pending_nxt = r_pending;
      w_sh_din_nxt  = r_sh_din;
      w_sh_dis_nxt  = r_sh_dis;
      w_sh_dp_nxt   = r_sh_dp;
      w_act_din_nxt = r_act_din;
      w_act_dis_nxt = r_act_dis;
      w_act_dp_nxt  = r_act_dp;
      w_frame_nxt   = 1'b0;
      w_an_nxt      = 8'hFF;
      w_seg_nxt     = 8'hFF;

      if (w_tick) begin
         w_presc_nxt = '0;
         w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
         w_presc_nxt = r_presc + PW'(1);
      end

      // Commit uses the pre-load shadow; a simultaneous load stays pending.
      if (w_wrap) begin
         if (r_pending) begin
            w_act_din_nxt = r_sh_din;
            w_act_dis_nxt = r_sh_dis;
            w_act_dp_nxt  = r_sh_dp;
            w_frame_nxt   = 1'b1;
         end
         w_pending_nxt = 1'b0;
      end

      if (bus.load) begin
         w_sh_din_nxt  = bus.din;
         w_sh_dis_nxt  = ~bus.den;
         w_sh_dp_nxt   = bus.dpin;
         w_pending_nxt = 1'b1;
      end

      if (w_en) begin
         w_an_nxt  = ~(8'h01 << r_idx);
         w_seg_nxt = {~w_dp, hex7(w_nib)};
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc   <= '0;
         r_idx     <= '0;
         r_pending <= 1'b0;
         r_sh_din  <= '0;
         r_sh_dis  <= '0;
         r_sh_dp   <= '0;
         r_act_din <= '0;
         r_act_dis <= '0;
         r_act_dp  <= '0;
         r_seg     <= 8'hFF;
         r_an      <= 8'hFF;
         r_frame   <= 1'b0;
      end else begin
         r_presc   <= w_presc_nxt;
         r_idx     <= w_idx_nxt;
         r_pending <= w_pending_nxt;
         r_sh_din  <= w_sh_din_nxt;
         r_sh_dis  <= w_sh_dis_nxt;
         r_sh_dp   <= w_sh_dp_nxt;
         r_act_din <= w_act_din_nxt;
         r_act_dis <= w_act_dis_nxt;
         r_act_dp  <= w_act_dp_nxt;
         r_seg     <= w_seg_nxt;
         r_an      <= w_an_nxt;
         r_frame   <= w_frame_nxt;
      end
   end

   assign bus.SEG   = r_seg;
   assign bus.AN    = r_an;
   assign bus.frame = r_frame;

endmodule : seg_scan_display

// File: tb/tb_seg_scan_display.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_display
// Directed bench: a 4-digit / divide-by-4 instance and a 1-digit / divide-by-1
// instance sharing clk and rst. Outputs are sampled on the falling edge.
// Frame timing for the 4-digit instance: a negedge just after a wrap edge is
// "t=0"; the next wrap edge is the 16th rising edge after it.
// ----------------------------------------------------------------------------
module tb_seg_scan_display;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   seg_scan_display_if #(.N_DIGITS(4)) bus4 ();
   seg_scan_display_if #(.N_DIGITS(1)) bus1 ();

   seg_scan_display #(.N_DIGITS(4), .CLK_DIV(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   seg_scan_display #(.N_DIGITS(1), .CLK_DIV(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset for 3 cycles, release, idle two frames with no load.
   task automatic test_reset;
      int frames;
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (bus4.SEG !== 8'hFF) begin n_err++; $display("FAIL reset_seg: got %h want ff", bus4.SEG); end
         n_cmp++;
         if (bus4.AN !== 8'hFF) begin n_err++; $display("FAIL reset_an: got %h want ff", bus4.AN); end
         n_cmp++;
         if (bus4.frame !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b want 0", bus4.frame); end
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus4.AN !== 8'hFE) begin n_err++; $display("FAIL release_an: got %h want fe", bus4.AN); end
      n_cmp++;
      if (bus4.SEG !== 8'hC0) begin n_err++; $display("FAIL release_seg: got %h want c0", bus4.SEG); end
      n_cmp++;
      if (bus1.AN !== 8'hFE) begin n_err++; $display("FAIL release_an1: got %h want fe", bus1.AN); end
      frames = int'(bus4.frame);
      repeat (31) begin
         @(negedge clk);
         frames += int'(bus4.frame);
      end
      n_cmp++;
      if (frames !== 0) begin n_err++; $display("FAIL idle_frames: got %0d want 0", frames); end
   endtask

   // Load 12AF, wait for the commit, then check all four 4-cycle slots.
   task automatic test_load_scan;
      logic [7:0] exp_an [4];
      logic [7:0] exp_seg[4];
      bit         got;
      int         frames;
      int         slot;
      exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      exp_seg = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
      bus4.din  = 16'h12AF;
      bus4.den  = 4'hF;
      bus4.dpin = 4'h0;
      bus4.load = 1'b1;
      @(negedge clk);
      bus4.load = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         if (bus4.frame === 1'b1) got = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!got) begin n_err++; $display("FAIL load_frame_seen: got 0 want 1"); end
      frames = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         slot = (k - 1) / 4;
         frames += int'(bus4.frame);
         n_cmp++;
         if (bus4.AN !== exp_an[slot]) begin
            n_err++; $display("FAIL scan_an[%0d]: got %h want %h", k, bus4.AN, exp_an[slot]);
         end
         n_cmp++;
         if (bus4.SEG !== exp_seg[slot]) begin
            n_err++; $display("FAIL scan_seg[%0d]: got %h want %h", k, bus4.SEG, exp_seg[slot]);
         end
         n_cmp++;
         if ($countones(~bus4.AN) > 1) begin
            n_err++; $display("FAIL an_onehot[%0d]: got %h want at most one low bit", k, bus4.AN);
         end
      end
      n_cmp++;
      if (frames !== 0) begin n_err++; $display("FAIL scan_extra_frames: got %0d want 0", frames); end
   endtask

   // Load one cycle before the wrap and again on the wrap cycle.
   task automatic test_back_to_back;
      int frames;
      frames = 0;
      bus4.den  = 4'hF;
      bus4.dpin = 4'h0;
      for (int t = 1; t <= 48; t++) begin
         @(negedge clk);
         frames += int'(bus4.frame);
         if (t == 16 || t == 32) begin
            n_cmp++;
            if (bus4.frame !== 1'b1) begin n_err++; $display("FAIL b2b_frame_t%0d: got %b want 1", t, bus4.frame); end
         end
         if (t == 17) begin
            n_cmp++;
            if (bus4.SEG !== 8'h92) begin n_err++; $display("FAIL b2b_first_seg: got %h want 92", bus4.SEG); end
            n_cmp++;
            if (bus4.AN !== 8'hFE) begin n_err++; $display("FAIL b2b_first_an: got %h want fe", bus4.AN); end
         end
         if (t == 33) begin
            n_cmp++;
            if (bus4.SEG !== 8'h90) begin n_err++; $display("FAIL b2b_second_seg: got %h want 90", bus4.SEG); end
         end
         if (t == 14) begin bus4.din = 16'h5555; bus4.load = 1'b1; end
         if (t == 15) bus4.din = 16'h9999;
         if (t == 16) bus4.load = 1'b0;
      end
      n_cmp++;
      if (frames !== 2) begin n_err++; $display("FAIL b2b_frame_count: got %0d want 2", frames); end
   endtask

   // Per-digit enable and decimal point masks.
   task automatic test_den_dp;
      bus4.din  = 16'h8888;
      bus4.den  = 4'b0101;
      bus4.dpin = 4'b0001;
      bus4.load = 1'b1;
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         bus4.load = 1'b0;
         if (t == 16) begin
            n_cmp++;
            if (bus4.frame !== 1'b1) begin n_err++; $display("FAIL den_frame: got %b want 1", bus4.frame); end
         end
         if (t == 17) begin
            n_cmp++;
            if ({bus4.AN, bus4.SEG} !== 16'hFE00) begin n_err++; $display("FAIL den_d0: got %h want fe00", {bus4.AN, bus4.SEG}); end
         end
         if (t == 21) begin
            n_cmp++;
            if ({bus4.AN, bus4.SEG} !== 16'hFFFF) begin n_err++; $display("FAIL den_d1: got %h want ffff", {bus4.AN, bus4.SEG}); end
         end
         if (t == 25) begin
            n_cmp++;
            if ({bus4.AN, bus4.SEG} !== 16'hFB80) begin n_err++; $display("FAIL den_d2: got %h want fb80", {bus4.AN, bus4.SEG}); end
         end
         if (t == 29) begin
            n_cmp++;
            if ({bus4.AN, bus4.SEG} !== 16'hFFFF) begin n_err++; $display("FAIL den_d3: got %h want ffff", {bus4.AN, bus4.SEG}); end
         end
      end
   endtask

   // Zero digits, with and without leading-zero blanking.
   task automatic test_lead_zero;
      logic [15:0] pat_din[2];
      logic [7:0]  exp_an [2][4];
      logic [7:0]  exp_seg[2][4];
      int          slot;
      pat_din = '{16'h0030, 16'h0000};
`ifdef SEG_LEADING_ZERO_BLANK_EN
      exp_an  = '{'{8'hFE, 8'hFD, 8'hFF, 8'hFF}, '{8'hFE, 8'hFF, 8'hFF, 8'hFF}};
      exp_seg = '{'{8'hC0, 8'hB0, 8'hFF, 8'hFF}, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}};
`else
      exp_an  = '{'{8'hFE, 8'hFD, 8'hFB, 8'hF7}, '{8'hFE, 8'hFD, 8'hFB, 8'hF7}};
      exp_seg = '{'{8'hC0, 8'hB0, 8'hC0, 8'hC0}, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`endif
      for (int p = 0; p < 2; p++) begin
         bus4.din  = pat_din[p];
         bus4.den  = 4'hF;
         bus4.dpin = 4'h0;
         bus4.load = 1'b1;
         for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            bus4.load = 1'b0;
            if (t == 17 || t == 21 || t == 25 || t == 29) begin
               slot = (t - 17) / 4;
               n_cmp++;
               if (bus4.AN !== exp_an[p][slot]) begin
                  n_err++; $display("FAIL lz_an p%0d d%0d: got %h want %h", p, slot, bus4.AN, exp_an[p][slot]);
               end
               n_cmp++;
               if (bus4.SEG !== exp_seg[p][slot]) begin
                  n_err++; $display("FAIL lz_seg p%0d d%0d: got %h want %h", p, slot, bus4.SEG, exp_seg[p][slot]);
               end
            end
         end
      end
   endtask

   // Reset mid-frame with a pending load: outputs and shadow data cleared.
   task automatic test_mid_reset;
      int frames;
      bus4.din  = 16'h1234;
      bus4.den  = 4'hF;
      bus4.dpin = 4'hF;
      bus4.load = 1'b1;
      @(negedge clk);
      bus4.load = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus4.AN, bus4.SEG} !== 16'hFFFF) begin n_err++; $display("FAIL midrst_out: got %h want ffff", {bus4.AN, bus4.SEG}); end
      n_cmp++;
      if (bus4.frame !== 1'b0) begin n_err++; $display("FAIL midrst_frame: got %b want 0", bus4.frame); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus4.AN, bus4.SEG} !== 16'hFEC0) begin n_err++; $display("FAIL midrst_release: got %h want fec0", {bus4.AN, bus4.SEG}); end
      frames = 0;
      repeat (40) begin
         @(negedge clk);
         frames += int'(bus4.frame);
      end
      n_cmp++;
      if (frames !== 0) begin n_err++; $display("FAIL midrst_lost_load: got %0d frames want 0", frames); end
   endtask

   // Single digit, advance every cycle: every cycle is a frame wrap.
   task automatic test_single_digit;
      logic [3:0] v_din[2];
      logic       v_dp [2];
      logic [7:0] v_seg[2];
      v_din = '{4'h7, 4'hA};
      v_dp  = '{1'b0, 1'b1};
      v_seg = '{8'hF8, 8'h08};
      for (int p = 0; p < 2; p++) begin
         bus1.din  = v_din[p];
         bus1.den  = 1'b1;
         bus1.dpin = v_dp[p];
         bus1.load = 1'b1;
         @(negedge clk);
         bus1.load = 1'b0;
         n_cmp++;
         if (bus1.frame !== 1'b0) begin n_err++; $display("FAIL sd_frame_early p%0d: got %b want 0", p, bus1.frame); end
         @(negedge clk);
         n_cmp++;
         if (bus1.frame !== 1'b1) begin n_err++; $display("FAIL sd_frame p%0d: got %b want 1", p, bus1.frame); end
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus1.AN !== 8'hFE) begin n_err++; $display("FAIL sd_an p%0d: got %h want fe", p, bus1.AN); end
            n_cmp++;
            if (bus1.frame !== 1'b0) begin n_err++; $display("FAIL sd_frame_after p%0d: got %b want 0", p, bus1.frame); end
            n_cmp++;
            if (bus1.SEG !== v_seg[p]) begin n_err++; $display("FAIL sd_seg p%0d: got %h want %h", p, bus1.SEG, v_seg[p]); end
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b1;
      bus4.load = 1'b0;
      bus4.din  = '0;
      bus4.den  = '0;
      bus4.dpin = '0;
      bus1.load = 1'b0;
      bus1.din  = '0;
      bus1.den  = '0;
      bus1.dpin = '0;

      test_reset();
      test_load_scan();
      test_back_to_back();
      test_den_dp();
      test_lead_zero();
      test_mid_reset();
      test_single_digit();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seg_scan_display
